// File: rtl/sync_chain_filter.sv
// Multi-channel async-input synchronizer: configurable flop chain, optional debounce filter, registered edge pulses.
// Latency STAGES edges (STAGES+FILTER_CYCLES with filter); no backpressure, every input is sampled each cycle.
module sync_chain_filter #(
    parameter int                  CHANNELS      = 4,
    parameter int                  STAGES        = 2,
    parameter logic [CHANNELS-1:0] RST_VAL       = '0,
    parameter int                  FILTER_CYCLES = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_async,
    output logic [CHANNELS-1:0] o_sync,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_changed
);
    localparam int CW = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);

    logic [CHANNELS-1:0] r_stage [STAGES];
    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_sync;
    logic [CHANNELS-1:0] w_sync_nxt;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic                r_changed;

    // Only stage 0 ever sees the asynchronous input.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) r_stage[k] <= RST_VAL;
        end else begin
            r_stage[0] <= i_async;
            for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign w_s = r_stage[STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign w_sync     = w_s;
            assign w_sync_nxt = r_stage[STAGES-2];
        end else begin : g_filter
            logic [CHANNELS-1:0] r_filt;
            logic [CW-1:0]       r_cnt [CHANNELS];
            logic [CHANNELS-1:0] w_hit;

            // A channel flips once it has disagreed with the filtered level for N edges in a row.
            always_comb begin
                w_hit = '0;
                for (int c = 0; c < CHANNELS; c++)
                    w_hit[c] = (w_s[c] != r_filt[c]) && (r_cnt[c] == CW'(FILTER_CYCLES - 1));
            end

            assign w_sync_nxt = r_filt ^ w_hit;
            assign w_sync     = r_filt;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_filt <= RST_VAL;
                    for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
                end else begin
                    r_filt <= w_sync_nxt;
                    for (int c = 0; c < CHANNELS; c++) begin
                        if ((w_s[c] == r_filt[c]) || w_hit[c]) r_cnt[c] <= '0;
                        else                                   r_cnt[c] <= r_cnt[c] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Pulses are computed from the level about to be loaded, so they align with the new o_sync.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_rise    <= w_sync_nxt & ~w_sync;
            r_fall    <= ~w_sync_nxt & w_sync;
            r_changed <= |(w_sync_nxt ^ w_sync);
        end
    end

    assign o_sync    = w_sync;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_changed = r_changed;
endmodule

// File: tb/tb_sync_chain_filter.sv
// Four differently configured synchronizers share one stimulus stream; a history-based model feeds a scoreboard.
module tb_sync_chain_filter;
    localparam int NI   = 4;
    localparam int MAXC = 4096;
    localparam int         STG [NI] = '{2, 3, 2, 4};
    localparam int         FLT [NI] = '{0, 4, 2, 1};
    localparam logic [3:0] RV  [NI] = '{4'h0, 4'hA, 4'h0, 4'h6};

    typedef struct packed {
        logic [3:0] sync;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } res_t;
    typedef res_t [NI-1:0] exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_async;
    logic [3:0] o_sync_w [NI];
    logic [3:0] o_rise_w [NI];
    logic [3:0] o_fall_w [NI];
    logic [NI-1:0] o_chg_w;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    sync_chain_filter #(.CHANNELS(4), .STAGES(2), .RST_VAL(4'h0), .FILTER_CYCLES(0)) u0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_async), .o_sync(o_sync_w[0]),
        .o_rise(o_rise_w[0]), .o_fall(o_fall_w[0]), .o_changed(o_chg_w[0]));
    sync_chain_filter #(.CHANNELS(4), .STAGES(3), .RST_VAL(4'hA), .FILTER_CYCLES(4)) u1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_async), .o_sync(o_sync_w[1]),
        .o_rise(o_rise_w[1]), .o_fall(o_fall_w[1]), .o_changed(o_chg_w[1]));
    sync_chain_filter #(.CHANNELS(4), .STAGES(2), .RST_VAL(4'h0), .FILTER_CYCLES(2)) u2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_async), .o_sync(o_sync_w[2]),
        .o_rise(o_rise_w[2]), .o_fall(o_fall_w[2]), .o_changed(o_chg_w[2]));
    sync_chain_filter #(.CHANNELS(4), .STAGES(4), .RST_VAL(4'h6), .FILTER_CYCLES(1)) u3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_async), .o_sync(o_sync_w[3]),
        .o_rise(o_rise_w[3]), .o_fall(o_fall_w[3]), .o_changed(o_chg_w[3]));

    // Model state: every input sample by edge index, plus the most recent reset edge.
    logic [3:0] samp [MAXC];
    int         t        = 0;
    int         rst_edge = 0;
    logic [3:0] m_sync [NI];
    exp_t       expq [$];

    // Chain output after edge u: the sample taken STAGES-1 edges earlier, or the reset value.
    function automatic logic [3:0] s_after(int i, int u);
        int src;
        src = u - STG[i] + 1;
        if (src > rst_edge) return samp[src];
        return RV[i];
    endfunction

    always @(posedge i_clk) begin
        exp_t       e;
        logic [3:0] nx;
        logic       ok;
        int         u;
        t++;
        if (t < MAXC) samp[t] = i_async;
        if (!i_rst_n) begin
            rst_edge = t;
            for (int i = 0; i < NI; i++) begin
                m_sync[i]  = RV[i];
                e[i].sync  = RV[i];
                e[i].rise  = 4'h0;
                e[i].fall  = 4'h0;
                e[i].chg   = 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (FLT[i] == 0) begin
                    nx = s_after(i, t);
                end else begin
                    nx = m_sync[i];
                    for (int ch = 0; ch < 4; ch++) begin
                        ok = 1'b1;
                        for (int j = 0; j < FLT[i]; j++) begin
                            u = t - 1 - j;
                            if (u < rst_edge) ok = 1'b0;
                            else if (s_after(i, u)[ch] == m_sync[i][ch]) ok = 1'b0;
                        end
                        if (ok) nx[ch] = ~m_sync[i][ch];
                    end
                end
                e[i].rise = nx & ~m_sync[i];
                e[i].fall = ~nx & m_sync[i];
                e[i].chg  = |(nx ^ m_sync[i]);
                e[i].sync = nx;
                m_sync[i] = nx;
            end
        end
        expq.push_back(e);
    end

    task automatic chk(input string nm, input int inst, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s u%0d edge=%0d actual=%h expected=%h", nm, inst, t, act, exp_v);
        end
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (t > 0) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty edge=%0d actual=0 expected=1", t);
            end else begin
                e = expq.pop_front();
                for (int i = 0; i < NI; i++) begin
                    chk("o_sync",    i, o_sync_w[i],          e[i].sync);
                    chk("o_rise",    i, o_rise_w[i],          e[i].rise);
                    chk("o_fall",    i, o_fall_w[i],          e[i].fall);
                    chk("o_changed", i, {3'b000, o_chg_w[i]}, {3'b000, e[i].chg});
                end
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_async = 4'hA;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (12) @(negedge i_clk);
        i_async = 4'h5;
        repeat (12) @(negedge i_clk);
        // Single rising edge on channel 0.
        i_async = 4'h0;
        repeat (10) @(negedge i_clk);
        i_async = 4'h1;
        repeat (10) @(negedge i_clk);
        // Short glitch on channel 1, then a long enough pulse.
        i_async = 4'h0;
        repeat (10) @(negedge i_clk);
        i_async = 4'h2;
        repeat (3) @(negedge i_clk);
        i_async = 4'h0;
        repeat (12) @(negedge i_clk);
        i_async = 4'h2;
        repeat (12) @(negedge i_clk);
        // Reset in the middle of a pending filter count.
        i_async = 4'h0;
        repeat (10) @(negedge i_clk);
        i_async = 4'h4;
        repeat (4) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (15) @(negedge i_clk);
        // Channel 3 toggling every third cycle.
        for (int k = 0; k < 34; k++) begin
            i_async[3] = ~i_async[3];
            repeat (3) @(negedge i_clk);
        end
        // Random per-channel flips with occasional mid-run resets.
        for (int k = 0; k < 2000; k++) begin
            @(negedge i_clk);
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 3) == 0) i_async[ch] = ~i_async[ch];
            i_rst_n = ($urandom_range(0, 199) != 0);
        end
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
